wb_gpio_arbiter: RTL and testbench

WB_GPIO_ARBITER -- requirements
Module: wb_gpio_arbiter

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_timeout_cnt.sv | 27 ++
 rtl/wb_gpio_arbiter.sv | 111 +++++++++++
 tb/tb_wb_gpio_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone GPIO arbiter.
// Covers the FSM state encoding, the master count and the owner one-hot helper.
package wb_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  function automatic logic [NUM_MASTERS-1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts wait cycles of a strobed access. Expiry is flagged combinationally when
// the count reaches TIMEOUT-1. Clear has priority over enable.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/wb_gpio_arbiter.sv
// Round-robin arbiter for two Wishbone masters sharing one GPIO slave.
// Grant lands 1 cycle after request; the slave path is combinational; stalled strobes abort after TIMEOUT cycles.
module wb_gpio_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_MASTERS-1:0]   m_cyc_i,
  input  logic [NUM_MASTERS-1:0]   m_stb_i,
  input  logic [NUM_MASTERS-1:0]   m_we_i,
  input  logic [NUM_MASTERS-1:0]   m_adr_i,
  input  logic [8*NUM_MASTERS-1:0] m_dat_i,
  output logic [8*NUM_MASTERS-1:0] m_dat_o,
  output logic [NUM_MASTERS-1:0]   m_ack_o,
  output logic [NUM_MASTERS-1:0]   m_err_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic                     s_adr_o,
  output logic [7:0]               s_dat_o,
  input  logic [7:0]               s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [NUM_MASTERS-1:0]   o_grant
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_owner, last_owner_nxt;
  logic       cnt_clear, cnt_en, cnt_expired;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (cnt_clear),
    .enable    (cnt_en),
    .expired   (cnt_expired)
  );

  // Read data is broadcast; only the acked master samples it.
  assign m_dat_o = {NUM_MASTERS{s_dat_i}};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      o_grant    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      o_grant    <= (state_nxt == ST_IDLE) ? '0 : owner_onehot(owner_nxt);
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_adr_o        = 1'b0;
    s_dat_o        = '0;
    m_ack_o        = '0;
    m_err_o        = '0;
    cnt_clear      = 1'b1;
    cnt_en         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_nxt = ST_BUSY;
          // On a tie the master that was not served last wins.
          owner_nxt = (&m_cyc_i) ? ~last_owner : m_cyc_i[1];
        end
      end

      ST_BUSY: begin
        s_cyc_o   = m_cyc_i[owner];
        s_stb_o   = m_cyc_i[owner] & m_stb_i[owner];
        s_we_o    = m_we_i[owner];
        s_adr_o   = m_adr_i[owner];
        s_dat_o   = owner ? m_dat_i[15:8] : m_dat_i[7:0];
        m_ack_o   = (s_ack_i & m_cyc_i[owner]) ? owner_onehot(owner) : '0;
        m_err_o   = (s_err_i & m_cyc_i[owner]) ? owner_onehot(owner) : '0;
        cnt_en    = 1'b1;
        cnt_clear = ~s_stb_o | s_ack_i | s_err_i;

        if (!m_cyc_i[owner]) begin
          state_nxt      = ST_IDLE;
          last_owner_nxt = owner;
        end else if (s_stb_o && cnt_expired && !s_ack_i && !s_err_i) begin
          state_nxt = ST_ABORT;
        end
      end

      ST_ABORT: begin
        m_err_o        = owner_onehot(owner);
        state_nxt      = ST_IDLE;
        last_owner_nxt = owner;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Directed and randomized bench for wb_gpio_arbiter with a behavioural GPIO slave
// (adr 0 = output register, adr 1 = direction register, ack one cycle after strobe).
module tb_wb_gpio_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we, m_adr;
  logic [15:0] m_dat;
  logic [15:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, o_grant;
  logic        s_cyc_o, s_stb_o, s_we_o, s_adr_o;
  logic [7:0]  s_dat_o, s_dat_i;
  logic        s_ack_i, s_err_i;

  logic [7:0]  gpio_o   = 8'h00;
  logic [7:0]  gpio_dir = 8'h00;
  logic        slv_ack  = 1'b0;
  logic        ack_en;
  logic        err_inj;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_gpio_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .o_grant   (o_grant)
  );

  // GPIO slave: registers the write on the strobe edge, acks in the following cycle.
  always @(posedge clk) begin
    slv_ack <= ack_en && s_cyc_o && s_stb_o && !slv_ack;
    if (ack_en && s_cyc_o && s_stb_o && !slv_ack && s_we_o) begin
      if (s_adr_o) gpio_dir <= s_dat_o;
      else         gpio_o   <= s_dat_o;
    end
  end
  assign s_ack_i = slv_ack;
  assign s_err_i = err_inj;
  assign s_dat_i = s_adr_o ? gpio_dir : gpio_o;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input int m, input logic we, input logic adr, input logic [7:0] dat);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_we[m]  = we;
    m_adr[m] = adr;
    m_dat[8*m +: 8] = dat;
  endtask

  task automatic drop(input int m);
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  // Reference model state for the randomized phase.
  int         own;
  int         last;
  logic [7:0] exp_reg [2];
  int         done_cnt [2];
  logic [1:0] ackd;
  logic [1:0] exp_ack;
  logic       own_act;

  initial begin
    rst_n = 1'b0; ack_en = 1'b1; err_inj = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;

    // Reset state
    smp();
    check("rst_scyc", s_cyc_o, 0);
    check("rst_sstb", s_stb_o, 0);
    check("rst_grant", o_grant, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    tick(); rst_n = 1'b1;

    // First tie after reset: master 0 wins, master 1 follows within 2 cycles
    tick(); req(0, 1, 0, 8'h5A); req(1, 1, 1, 8'h0F);
    smp(); check("tie_idle_grant", o_grant, 2'b00);
    tick(); smp();
    check("tie_grant0", o_grant, 2'b01);
    check("tie_sdat0", s_dat_o, 8'h5A);
    check("tie_ack_early", m_ack_o, 2'b00);
    tick(); smp();
    check("tie_ack0", m_ack_o, 2'b01);
    check("tie_gpio", gpio_o, 8'h5A);
    tick(); drop(0); smp();
    check("rel_scyc", s_cyc_o, 0);
    tick(); smp(); check("rel_gap_grant", o_grant, 2'b00);
    tick(); smp();
    check("rr_grant1", o_grant, 2'b10);
    check("rr_sadr1", s_adr_o, 1);
    check("rr_sdat1", s_dat_o, 8'h0F);
    tick(); smp();
    check("rr_ack1", m_ack_o, 2'b10);
    check("rr_dir", gpio_dir, 8'h0F);
    tick(); drop(1);
    tick();

    // Second tie: master 0 wins again; then master 1 reads dir
    tick(); req(0, 0, 0, 8'h00); req(1, 0, 1, 8'h00);
    tick(); smp(); check("tie2_grant0", o_grant, 2'b01);
    tick(); smp();
    check("rd0_ack", m_ack_o, 2'b01);
    check("rd0_dat", m_dat_o[7:0], 8'h5A);
    tick(); drop(0);
    tick(); tick(); smp(); check("rd1_grant", o_grant, 2'b10);
    tick(); smp();
    check("rd1_ack", m_ack_o, 2'b10);
    check("rd1_dat", m_dat_o[15:8], 8'h0F);
    tick(); drop(1);
    tick();

    // Single requester write: one-cycle grant latency, one-cycle ack
    tick(); req(0, 1, 0, 8'hA5);
    smp(); check("lat_idle_scyc", s_cyc_o, 0);
    tick(); smp();
    check("lat_scyc", s_cyc_o, 1);
    check("lat_swe", s_we_o, 1);
    tick(); smp();
    check("wr_ack", m_ack_o, 2'b01);
    check("wr_gpio", gpio_o, 8'hA5);
    tick(); drop(0); smp(); check("wr_ack_once", m_ack_o, 2'b00);
    tick(); smp(); check("wr_idle_grant", o_grant, 2'b00);

    // Timeout: slave never acks, abort after TMO strobed cycles
    ack_en = 1'b0;
    tick(); req(0, 1, 1, 8'h77);
    for (int i = 0; i < TMO; i++) begin
      tick(); smp();
      check("tmo_wait_scyc", s_cyc_o, 1);
      check("tmo_wait_err", m_err_o, 2'b00);
    end
    tick(); smp();
    check("tmo_err", m_err_o, 2'b01);
    check("tmo_scyc", s_cyc_o, 0);
    check("tmo_sstb", s_stb_o, 0);
    check("tmo_grant", o_grant, 2'b01);
    tick(); drop(0); smp();
    check("tmo_err_once", m_err_o, 2'b00);
    check("tmo_idle_grant", o_grant, 2'b00);

    // Slave error forwarding, then master 1 gives up mid-wait
    tick(); req(1, 0, 0, 8'h00);
    tick(); smp(); check("err_grant", o_grant, 2'b10);
    tick(); err_inj = 1'b1; smp();
    check("err_fwd", m_err_o, 2'b10);
    check("err_noack", m_ack_o, 2'b00);
    tick(); err_inj = 1'b0; drop(1); smp();
    check("drop_scyc", s_cyc_o, 0);
    check("drop_err", m_err_o, 2'b00);
    tick(); smp(); check("drop_grant", o_grant, 2'b00);

    // Reset mid-BUSY
    tick(); req(0, 0, 0, 8'h00);
    tick(); smp(); check("mrst_busy_grant", o_grant, 2'b01);
    #2; rst_n = 1'b0; #1;
    check("mrst_scyc", s_cyc_o, 0);
    check("mrst_grant", o_grant, 2'b00);
    check("mrst_err", m_err_o, 2'b00);
    tick(); drop(0); smp(); check("mrst_hold_err", m_err_o, 2'b00);
    tick(); rst_n = 1'b1; ack_en = 1'b1;
    req(0, 0, 0, 8'h00); req(1, 0, 0, 8'h00);
    smp(); check("mrst_nopend", o_grant, 2'b00);
    tick(); smp(); check("mrst_tie", o_grant, 2'b01);
    tick(); drop(0); drop(1);
    tick(); tick();

    // Randomized traffic against a transaction-level model
    own = -1; last = 0;
    exp_reg[0] = 8'hA5; exp_reg[1] = 8'h0F;
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int c = 0; c < 500; c++) begin
      smp();
      own_act = (own >= 0) && m_cyc[own];
      check("rnd_grant", o_grant, (own < 0) ? 2'b00 : 2'(1 << own));
      check("rnd_scyc", s_cyc_o, own_act);
      check("rnd_err", m_err_o, 2'b00);
      exp_ack = (own_act && s_ack_i) ? 2'(1 << own) : 2'b00;
      check("rnd_ack", m_ack_o, exp_ack);
      if (own_act) begin
        check("rnd_sadr", s_adr_o, m_adr[own]);
        check("rnd_swe", s_we_o, m_we[own]);
        check("rnd_sdat", s_dat_o, m_dat[8*own +: 8]);
      end
      ackd = exp_ack;
      if (exp_ack != 2'b00) begin
        if (m_we[own]) exp_reg[m_adr[own]] = m_dat[8*own +: 8];
        else check("rnd_rdat", m_dat_o[8*own +: 8], exp_reg[m_adr[own]]);
        done_cnt[own]++;
      end
      @(posedge clk);
      if (own >= 0 && !m_cyc[own]) begin
        last = own;
        own  = -1;
      end else if (own < 0 && m_cyc != 2'b00) begin
        if (m_cyc == 2'b11) own = 1 - last;
        else                own = m_cyc[1] ? 1 : 0;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        if (ackd[m]) drop(m);
        else if (!m_cyc[m] && $urandom_range(0, 1) == 1)
          req(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end
    drop(0); drop(1);
    tick(); tick(); tick();
    check("rnd_gpio_o", gpio_o, exp_reg[0]);
    check("rnd_gpio_dir", gpio_dir, exp_reg[1]);
    check("rnd_m0_served", 16'(done_cnt[0] > 10), 1);
    check("rnd_m1_served", 16'(done_cnt[1] > 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
